// File: rtl/cam_arbiter_pkg.sv
// Shared types and sizes for the CAM port arbiter: operation encoding,
// CAM geometry, the per-requester request bundle and the in-flight tag.
package cam_arbiter_pkg;

    localparam int CAM_DEPTH  = 32;
    localparam int CAM_IDX_W  = $clog2(CAM_DEPTH);
    localparam int CAM_DATA_W = 32;

    // Wide enough to name any of up to eight requesters
    localparam int REQ_ID_W   = 3;

    typedef enum logic [1:0] {
        CAM_OP_READ   = 2'd0,
        CAM_OP_WRITE  = 2'd1,
        CAM_OP_SEARCH = 2'd2,
        CAM_OP_RSVD   = 2'd3
    } cam_op_e;

    typedef struct packed {
        cam_op_e                op;
        logic [CAM_IDX_W-1:0]   index;
        logic [CAM_DATA_W-1:0]  data;
    } cam_req_t;

    // Travels alongside an issued operation so its result can be routed home
    typedef struct packed {
        logic                   valid;
        logic [REQ_ID_W-1:0]    id;
        cam_op_e                op;
    } cam_tag_t;

    // Slice one requester's fields out of the flattened request buses
    function automatic cam_req_t pick_req(
        input logic [1:0]            op,
        input logic [CAM_IDX_W-1:0]  index,
        input logic [CAM_DATA_W-1:0] data
    );
        cam_req_t r;
        r.op    = cam_op_e'(op);
        r.index = index;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/cam_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among the request vector, searching
// from the slot after the previous winner. The pointer moves only when the
// grant is actually taken, so idle cycles do not disturb the rotation.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;

    // Walk the requesters starting just past the last winner; the previous
    // winner is visited last, which keeps every held request starvation-free
    always_comb begin
        int   slot;
        logic found;
        slot      = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 1; i <= N; i++) begin
            slot = (int'(ptr) + i) % N;
            if (!found && req[slot]) begin
                found       = 1'b1;
                grant[slot] = 1'b1;
                grant_idx   = PTR_W'(slot);
            end
        end
    end

    // Remember the last accepted winner; reset makes requester 0 first in line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PTR_W'(N - 1);
        end else if (accept && (grant != '0)) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/cam_arbiter.sv
// Shares the single CAM port among NUM_REQ requesters. One operation is
// accepted per cycle by round-robin, issued to the CAM from registers the
// following cycle, and its result is routed back to the issuing requester
// CAM_LAT cycles later using a tag that shadows the CAM pipeline.
module cam_arbiter
    import cam_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CAM_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [CAM_IDX_W*NUM_REQ-1:0]   req_index,
    input  logic [CAM_DATA_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,

    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic                           rsp_hit,
    output logic [CAM_DATA_W-1:0]          rsp_data,
    output logic [CAM_IDX_W-1:0]           rsp_index,

    output logic                           cam_read_enable,
    output logic [CAM_IDX_W-1:0]           cam_read_index,
    output logic                           cam_write_enable,
    output logic [CAM_IDX_W-1:0]           cam_write_index,
    output logic [CAM_DATA_W-1:0]          cam_write_data,
    output logic                           cam_search_enable,
    output logic [CAM_DATA_W-1:0]          cam_search_data,

    input  logic                           cam_read_valid,
    input  logic [CAM_DATA_W-1:0]          cam_read_value,
    input  logic                           cam_search_valid,
    input  logic [CAM_IDX_W-1:0]           cam_search_index
);

    cam_req_t              req_vec [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    cam_req_t              win_req;
    logic [REQ_ID_W-1:0]   win_id;
    cam_tag_t              issue_tag;
    cam_tag_t              tag_q [CAM_LAT+1];
    cam_tag_t              head;

    // Unflatten the per-requester buses into request bundles
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = pick_req(req_op[2*i +: 2],
                                  req_index[CAM_IDX_W*i +: CAM_IDX_W],
                                  req_data[CAM_DATA_W*i +: CAM_DATA_W]);
        end
    end

    rr_arbiter #(
        .N      (NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // The CAM never back-pressures, so the winner is always accepted; ready
    // is held low while reset is asserted so every output reads zero
    always_comb begin
        req_ready = rst_n ? grant : '0;
        accept    = |req_ready;
    end

    // Select the accepted request and its id from the one-hot grant
    always_comb begin
        win_req = '0;
        win_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                win_req = req_vec[i];
                win_id  = REQ_ID_W'(i);
            end
        end
    end

    // Register the accepted op onto the CAM port: one enable for one cycle,
    // while index/data keep their last value between operations; the
    // reserved op is accepted but touches no CAM enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_read_enable   <= 1'b0;
            cam_read_index    <= '0;
            cam_write_enable  <= 1'b0;
            cam_write_index   <= '0;
            cam_write_data    <= '0;
            cam_search_enable <= 1'b0;
            cam_search_data   <= '0;
        end else begin
            cam_read_enable   <= 1'b0;
            cam_write_enable  <= 1'b0;
            cam_search_enable <= 1'b0;
            if (accept) begin
                case (win_req.op)
                    CAM_OP_READ: begin
                        cam_read_enable <= 1'b1;
                        cam_read_index  <= win_req.index;
                    end
                    CAM_OP_WRITE: begin
                        cam_write_enable <= 1'b1;
                        cam_write_index  <= win_req.index;
                        cam_write_data   <= win_req.data;
                    end
                    CAM_OP_SEARCH: begin
                        cam_search_enable <= 1'b1;
                        cam_search_data   <= win_req.data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Tag describing what was accepted this cycle
    always_comb begin
        issue_tag.valid = accept;
        issue_tag.id    = win_id;
        issue_tag.op    = win_req.op;
    end

    // Shift tags in lock-step with the CAM: stage 0 lines up with the issue
    // cycle and the last stage lines up with the CAM result; reset drops
    // every in-flight tag so no stale response can appear afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= CAM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= issue_tag;
            for (int k = 1; k <= CAM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign head = tag_q[CAM_LAT];

    // Route the CAM result to the tagged requester; every response field is
    // zero whenever no tag is at the head of the pipeline
    always_comb begin
        rsp_valid = '0;
        rsp_hit   = 1'b0;
        rsp_data  = '0;
        rsp_index = '0;
        if (head.valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (head.id == REQ_ID_W'(i)) begin
                    rsp_valid[i] = 1'b1;
                end
            end
            case (head.op)
                CAM_OP_READ: begin
                    rsp_hit  = cam_read_valid;
                    rsp_data = cam_read_value;
                end
                CAM_OP_SEARCH: begin
                    rsp_hit   = cam_search_valid;
                    rsp_index = cam_search_index;
                end
                CAM_OP_WRITE: begin
                    rsp_hit = 1'b1;
                end
                default: begin
                    rsp_hit = 1'b0;
                end
            endcase
        end
    end

endmodule
